// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_pkg
// Description : Shared types and constants for the score binary-to-BCD path.
// Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_CODE  = 4'hF;
    localparam int         MAX_DISPLAY = 99;

    // Double-dabble correction of one BCD nibble ahead of the left shift.
    function automatic logic [3:0] dabble_nibble(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_dabble_step
// Description : Combinational add-3 correction of a 3-digit BCD scratch.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_dabble_step
    import score_pkg::*;
(
    input  logic [11:0] scratch,
    output logic [11:0] corrected
);

    for (genvar i = 0; i < 3; i++) begin : g_nib
        assign corrected[4*i +: 4] = dabble_nibble(scratch[4*i +: 4]);
    end

endmodule
`default_nettype wire

// File: rtl/score_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : score_bcd_conv
// Description : Sequential double-dabble converter driving a two-digit display.
// Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_conv
    import score_pkg::*;
#(
    parameter int IN_W     = 7,
    parameter int BLANK_LZ = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] bin_in,
    output logic            out_valid,
    output logic [3:0]      num_ten,
    output logic [3:0]      num_one,
    output logic            ovf
);

    localparam int CNT_W = $clog2(IN_W + 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [IN_W-1:0]   r_bin;
    logic [11:0]       r_scratch;
    logic [11:0]       w_corrected;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_lost;
    logic              r_out_valid;
    logic [3:0]        r_num_ten;
    logic [3:0]        r_num_one;
    logic              r_ovf;

    logic              w_over;
    logic [3:0]        w_ten;
    logic [3:0]        w_one;

    bcd_dabble_step u_step (
        .scratch   (w_corrected_src()),
        .corrected (w_corrected)
    );

    function automatic logic [11:0] w_corrected_src();
        return r_scratch;
    endfunction

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)                w_next_state = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CNT_W'(1))      w_next_state = ST_DONE;
            ST_DONE:  if (r_out_valid)             w_next_state = ST_IDLE;
            default:                               w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_lost remembers a digit carried past the hundreds nibble (value >= 1000).
    always_comb begin
        w_over = r_lost || (r_scratch[11:8] != 4'd0);
        w_one  = BLANK_CODE;
        w_ten  = BLANK_CODE;
        if (!w_over) begin
            w_one = r_scratch[3:0];
            if ((BLANK_LZ != 0) && (r_scratch[7:4] == 4'd0)) begin
                w_ten = BLANK_CODE;
            end else begin
                w_ten = r_scratch[7:4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin       <= '0;
            r_scratch   <= '0;
            r_cnt       <= '0;
            r_lost      <= 1'b0;
            r_out_valid <= 1'b0;
            r_num_ten   <= BLANK_CODE;
            r_num_one   <= BLANK_CODE;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (in_valid) begin
                        r_bin     <= bin_in;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(IN_W);
                        r_lost    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= {w_corrected[10:0], r_bin[IN_W-1]};
                    r_lost    <= r_lost | w_corrected[11];
                    r_bin     <= {r_bin[IN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt - CNT_W'(1);
                end
                ST_DONE: begin
                    // First DONE edge publishes the result, second one closes the pulse.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_num_ten   <= w_ten;
                        r_num_one   <= w_one;
                        r_ovf       <= w_over;
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign num_ten   = r_num_ten;
    assign num_one   = r_num_one;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: doc/score_bcd_conv.md
SCORE_BCD_CONV -- requirements
Module: score_bcd_conv

Interface
REQ-001 Parameter IN_W, default 7: binary input width; legal range 4..10.
REQ-002 Parameter BLANK_LZ, default 1: 1 replaces a zero tens digit with the blank code.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  bin_in holds a value to convert.
REQ-006 in_ready  out  1  converter idle and accepting input.
REQ-007 bin_in  in  IN_W  unsigned binary score.
REQ-008 out_valid  out  1  one-cycle pulse when num_ten, num_one and ovf are updated.
REQ-009 num_ten  out  4  tens digit 0..9, or 4'hF for blank.
REQ-010 num_one  out  4  ones digit 0..9, or 4'hF for blank.
REQ-011 ovf  out  1  last converted value exceeded 99.

Function
REQ-012 The block SHALL use an FSM with states IDLE, SHIFT and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; acceptance occurs on an edge where in_valid=1 and in_ready=1.
REQ-014 On acceptance the block SHALL capture bin_in, clear a 12-bit BCD scratch (hundreds/tens/ones), load bit counter=IN_W and enter SHIFT.
REQ-015 Each SHIFT cycle SHALL do two things: (a) add 3 to every scratch nibble >=5; (b) shift the corrected scratch left 1 bit, with the MSB of the captured binary entering bit 0; then shift the binary left and decrement the counter.
REQ-016 SHIFT SHALL last exactly IN_W cycles, then enter DONE.
REQ-017 In DONE the block SHALL register its outputs, assert out_valid for exactly one cycle and return to IDLE on the next edge.
REQ-018 Latency: for acceptance at edge N, out_valid SHALL be high in the cycle after edge N+IN_W+1; in_ready SHALL return one cycle later.
REQ-019 If the hundreds nibble is nonzero (value >99), the block SHALL set ovf=1 and num_ten=num_one=4'hF.
REQ-020 Otherwise the block SHALL set ovf=0 and num_one=ones nibble. num_ten SHALL be 4'hF when BLANK_LZ=1 and tens==0; in every other case it SHALL be the tens nibble.
REQ-021 num_ten, num_one and ovf SHALL hold their values between out_valid pulses.
REQ-022 in_valid while in_ready=0 SHALL be ignored: no capture, no queuing, no effect on the conversion in progress.
REQ-023 Value 0 SHALL produce num_one=0. num_ten SHALL be 4'hF when BLANK_LZ=1 and 0 when BLANK_LZ=0.

Reset
REQ-024 Reset SHALL force state=IDLE, out_valid=0, ovf=0, num_ten=num_one=4'hF, and clear the scratch, binary and counter registers.
REQ-025 Reset during SHIFT or DONE SHALL abort the conversion with no out_valid pulse; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-026 Reset SHALL take priority over acceptance on the same edge.

Structure
REQ-027 Package score_pkg SHALL hold the state enum, BLANK_CODE=4'hF and MAX_DISPLAY=99.
REQ-028 The nibble correction SHALL be a combinational sub-module bcd_dabble_step: 12-bit scratch in, corrected 12-bit scratch out, instantiated once.
REQ-029 The num_ten/num_one outputs SHALL connect directly to the team's existing 7-segment digit decoder; codes A..F display blank there.

Verification
REQ-030 The bench SHALL cover each scenario below:
- bin_in=42 accepted at edge 0 (IN_W=7): out_valid after edge 8, num_ten=4, num_one=2, ovf=0.
- bin_in=7: BLANK_LZ=1 gives num_ten=F, num_one=7; BLANK_LZ=0 gives num_ten=0, num_one=7.
- bin_in=99 gives 9/9, ovf=0; bin_in=100 and bin_in=127 each give F/F, ovf=1.
- Convert 42, then assert in_valid with bin_in=13 every cycle of SHIFT: no capture. After in_ready returns, 13 converts to 1/3 and exactly two out_valid pulses are seen.
- Assert reset at SHIFT cycle 3: no out_valid, outputs F/F, ovf=0. The next conversion (5) gives F/5.
- Sweep 0..127 against a reference model: every result and every latency matches.
